// File: rtl/updown_counter_n.sv
// updown_counter_n: tick-driven up/down counter behind raw board buttons.
// Buttons are synchronised, debounced and turned into press-to-toggle events.

module ButtonDebounce #(
  parameter int unsigned DB_CYC     = 1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_press_evt
);

  localparam logic        RELEASED = ACTIVE_LOW;
  localparam int unsigned CW       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_evt;
  logic [CW-1:0] r_cnt;
  logic          w_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RELEASED;
      r_sync2 <= RELEASED;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2 ^ ACTIVE_LOW;

  // Stable level moves only after DB_CYC consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_evt      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_evt      <= r_stable & ~r_stable_d;
      if (w_level == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYC - 1)) begin
        r_stable <= w_level;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press_evt = r_evt;

endmodule

module updown_counter_n #(
  parameter int unsigned F_CLK_HZ       = 25_000_000,
  parameter int unsigned TICK_MS        = 1000,
  parameter int unsigned WIDTH          = 6,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter bit          SATURATE       = 1'b0,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_pause,
  input  logic             btn_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             dir_up,
  output logic             running,
  output logic             tick,
  output logic             led,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned TICK_CYC = (F_CLK_HZ / 1000) * TICK_MS;
  localparam int unsigned DB_RAW   = (F_CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DB_CYC   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int unsigned TCW      = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [WIDTH-1:0] Q_MAX = '1;

  typedef enum logic {RUN, PAUSED} run_state_t;

  logic [TCW-1:0]   r_tick_cnt;
  logic             r_tick;
  run_state_t       r_state;
  logic             r_dir_up;
  logic [WIDTH-1:0] r_q;
  logic             w_pause_evt;
  logic             w_dir_evt;

  ButtonDebounce #(.DB_CYC(DB_CYC), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_pause (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_pin       (btn_pause),
    .o_press_evt (w_pause_evt)
  );

  ButtonDebounce #(.DB_CYC(DB_CYC), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_dir (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_pin       (btn_dir),
    .o_press_evt (w_dir_evt)
  );

  // tick is registered one count early so it lines up with the last count value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (TICK_CYC <= 1) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= (r_tick_cnt == TCW'(TICK_CYC - 1)) ? '0 : r_tick_cnt + 1'b1;
      r_tick     <= (r_tick_cnt == TCW'(TICK_CYC - 2));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= RUN;
      r_dir_up <= 1'b1;
    end else begin
      if (w_pause_evt) r_state <= (r_state == RUN) ? PAUSED : RUN;
      if (w_dir_evt)   r_dir_up <= ~r_dir_up;
    end
  end

  // Load beats a step; a step uses the run/direction values from before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (r_tick && (r_state == RUN)) begin
      if (r_dir_up) begin
        if (!(SATURATE && (r_q == Q_MAX))) r_q <= r_q + 1'b1;
      end else begin
        if (!(SATURATE && (r_q == '0))) r_q <= r_q - 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign dir_up  = r_dir_up;
  assign running = (r_state == RUN);
  assign tick    = r_tick;
  assign led     = (TICK_CYC <= 1) ? 1'b1 : (r_tick_cnt < TCW'(TICK_CYC / 2));
  assign at_max  = (r_q == Q_MAX);
  assign at_min  = (r_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: wrap and saturate instances side by side, checked each cycle
// against a sample-history reference model through an expectation queue.

module tb_updown_counter_n;

  localparam int F_CLK_HZ    = 10_000;
  localparam int TICK_MS     = 1;
  localparam int DEBOUNCE_MS = 1;
  localparam int WIDTH       = 4;
  localparam int TICK_CYC    = 10;
  localparam int DB_CYC      = 10;
  localparam int QMOD        = 16;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             btn_pause = 1'b1;
  logic             btn_dir   = 1'b1;
  logic             load      = 1'b0;
  logic [WIDTH-1:0] load_val  = '0;

  logic [WIDTH-1:0] qW, qS;
  logic dirW, dirS, runW, runS, tickW, tickS, ledW, ledS, maxW, maxS, minW, minS;

  int nCompared   = 0;
  int nMismatched = 0;

  updown_counter_n #(.F_CLK_HZ(F_CLK_HZ), .TICK_MS(TICK_MS), .WIDTH(WIDTH),
                     .DEBOUNCE_MS(DEBOUNCE_MS), .SATURATE(1'b0), .BTN_ACTIVE_LOW(1'b1)) dutWrap (
    .clk(clk), .reset_n(reset_n), .btn_pause(btn_pause), .btn_dir(btn_dir),
    .load(load), .load_val(load_val), .q(qW), .dir_up(dirW), .running(runW),
    .tick(tickW), .led(ledW), .at_max(maxW), .at_min(minW)
  );

  updown_counter_n #(.F_CLK_HZ(F_CLK_HZ), .TICK_MS(TICK_MS), .WIDTH(WIDTH),
                     .DEBOUNCE_MS(DEBOUNCE_MS), .SATURATE(1'b1), .BTN_ACTIVE_LOW(1'b1)) dutSat (
    .clk(clk), .reset_n(reset_n), .btn_pause(btn_pause), .btn_dir(btn_dir),
    .load(load), .load_val(load_val), .q(qS), .dir_up(dirS), .running(runS),
    .tick(tickS), .led(ledS), .at_max(maxS), .at_min(minS)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] qWrap;
    logic [3:0] qSat;
    logic       running;
    logic       dirUp;
    logic       tick;
    logic       led;
  } exp_t;

  exp_t expQ[$];

  // Reference model: counts edges since reset, keeps a history of sampled pin levels.
  int mQW, mQS, mCnt;
  bit mRun, mDir;
  bit mStable[2];
  bit mRise[2];
  bit mEvt[2];
  bit hist[2][DB_CYC+2];

  function automatic void modelReset();
    mQW = 0; mQS = 0; mCnt = 0; mRun = 1'b1; mDir = 1'b1;
    for (int b = 0; b < 2; b++) begin
      mStable[b] = 1'b0; mRise[b] = 1'b0; mEvt[b] = 1'b0;
      for (int i = 0; i < DB_CYC + 2; i++) hist[b][i] = 1'b0;
    end
  endfunction

  function automatic void modelStep();
    bit stepNow;
    bit pressedNow[2];
    bit allDiff;
    stepNow = (mCnt == TICK_CYC - 1) && mRun;
    if (load) begin
      mQW = int'(load_val);
      mQS = int'(load_val);
    end else if (stepNow) begin
      if (mDir) begin
        mQW = (mQW + 1) % QMOD;
        mQS = (mQS < QMOD - 1) ? mQS + 1 : mQS;
      end else begin
        mQW = (mQW + QMOD - 1) % QMOD;
        mQS = (mQS > 0) ? mQS - 1 : 0;
      end
    end
    if (mEvt[0]) mRun = !mRun;
    if (mEvt[1]) mDir = !mDir;
    pressedNow[0] = (btn_pause == 1'b0);
    pressedNow[1] = (btn_dir == 1'b0);
    for (int b = 0; b < 2; b++) begin
      mEvt[b]  = mRise[b];
      mRise[b] = 1'b0;
      for (int i = DB_CYC + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = pressedNow[b];
      // The debouncer sees samples two edges old; it needs DB_CYC of them disagreeing.
      allDiff = 1'b1;
      for (int i = 2; i < DB_CYC + 2; i++) if (hist[b][i] == mStable[b]) allDiff = 1'b0;
      if (allDiff) begin
        mStable[b] = !mStable[b];
        mRise[b]   = mStable[b];
      end
    end
    mCnt = (mCnt + 1) % TICK_CYC;
  endfunction

  function automatic exp_t expRecord();
    exp_t e;
    e.qWrap   = 4'(mQW);
    e.qSat    = 4'(mQS);
    e.running = mRun;
    e.dirUp   = mDir;
    e.tick    = (mCnt == TICK_CYC - 1);
    e.led     = (mCnt < TICK_CYC / 2);
    return e;
  endfunction

  initial modelReset();

  always @(posedge clk) begin
    if (!reset_n) modelReset();
    else modelStep();
    expQ.push_back(expRecord());
  end

  // An asynchronous reset overrides the expectation already queued for this cycle.
  always @(negedge reset_n) begin
    modelReset();
    if (expQ.size() > 0) begin
      void'(expQ.pop_back());
      expQ.push_back(expRecord());
    end
  end

  task automatic checkOutput();
    exp_t e;
    bit bad;
    nCompared++;
    if (expQ.size() == 0) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard @%0t: DUT output with no queued expectation", $time);
      return;
    end
    e = expQ.pop_front();
    bad = (qW !== e.qWrap) || (qS !== e.qSat) ||
          (runW !== e.running) || (runS !== e.running) ||
          (dirW !== e.dirUp) || (dirS !== e.dirUp) ||
          (tickW !== e.tick) || (tickS !== e.tick) ||
          (ledW !== e.led) || (ledS !== e.led) ||
          (maxW !== (e.qWrap == 4'd15)) || (maxS !== (e.qSat == 4'd15)) ||
          (minW !== (e.qWrap == 4'd0)) || (minS !== (e.qSat == 4'd0));
    if (bad) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard @%0t: got qW=%0d qS=%0d run=%b%b dir=%b%b tick=%b%b led=%b%b max=%b%b min=%b%b, expected qW=%0d qS=%0d run=%b dir=%b tick=%b led=%b",
               $time, qW, qS, runW, runS, dirW, dirS, tickW, tickS, ledW, ledS, maxW, maxS, minW, minS,
               e.qWrap, e.qSat, e.running, e.dirUp, e.tick, e.led);
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic checkValue(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setPin(input int which, input bit pressed);
    if (which == 0) btn_pause = ~pressed;
    else            btn_dir   = ~pressed;
  endtask

  task automatic pressButton(input int which, input int hold, input bit bouncy);
    if (bouncy) begin
      int n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        setPin(which, (i % 2) == 0);
        waitCycles($urandom_range(1, 4));
      end
    end
    setPin(which, 1'b1);
    waitCycles(hold);
    setPin(which, 1'b0);
  endtask

  task automatic waitForCount(input int target);
    for (int i = 0; i < TICK_CYC && mCnt != target; i++) waitCycles(1);
  endtask

  task automatic applyStimulus();
    int kind = $urandom_range(0, 5);
    case (kind)
      0: waitCycles($urandom_range(1, 25));
      1: begin
        load_val = 4'($urandom_range(0, 15));
        load = 1'b1;
        waitCycles(1);
        load = 1'b0;
      end
      2: begin
        pressButton($urandom_range(0, 1), $urandom_range(12, 30), 1'b0);
        waitCycles($urandom_range(5, 20));
      end
      3: begin
        pressButton($urandom_range(0, 1), $urandom_range(1, 8), 1'b0);
        waitCycles($urandom_range(1, 10));
      end
      4: begin
        pressButton($urandom_range(0, 1), $urandom_range(12, 25), 1'b1);
        waitCycles($urandom_range(5, 20));
      end
      default: begin
        if ($urandom_range(0, 7) == 0) begin
          reset_n = 1'b0;
          waitCycles($urandom_range(1, 3));
          reset_n = 1'b1;
        end else begin
          waitCycles($urandom_range(1, 10));
        end
      end
    endcase
  endtask

  initial begin
    waitCycles(3);
    reset_n = 1'b1;
    checkValue("reset q", int'(qW), 0);
    checkValue("reset running", int'(runW), 1);
    checkValue("reset dir_up", int'(dirW), 1);
    checkValue("reset led", int'(ledW), 1);
    checkValue("reset tick", int'(tickW), 0);

    waitCycles(50);
    checkValue("count after 50 cycles", int'(qW), 5);

    load_val = 4'd14;
    load = 1'b1;
    waitCycles(1);
    load = 1'b0;
    waitCycles(30);
    checkValue("wrap up q", int'(qW), 1);
    checkValue("saturate up q", int'(qS), 15);

    pressButton(1, 15, 1'b0);
    waitCycles(20);
    load_val = 4'd1;
    load = 1'b1;
    waitCycles(1);
    load = 1'b0;
    waitCycles(30);
    checkValue("wrap down q", int'(qW), 14);
    checkValue("saturate down q", int'(qS), 0);
    checkValue("dir after press", int'(dirW), 0);

    for (int i = 0; i < 7; i++) begin
      btn_pause = ~btn_pause;
      waitCycles(3);
    end
    btn_pause = 1'b0;
    waitCycles(30);
    btn_pause = 1'b1;
    waitCycles(20);
    checkValue("paused after bouncy press", int'(runW), 0);
    waitCycles(30);
    pressButton(0, 15, 1'b0);
    waitCycles(20);
    checkValue("running after clean press", int'(runW), 1);

    waitForCount(TICK_CYC - 1);
    load_val = 4'd7;
    load = 1'b1;
    waitCycles(1);
    load = 1'b0;
    checkValue("load on tick wrap", int'(qW), 7);
    checkValue("load on tick sat", int'(qS), 7);

    waitForCount(6);
    pressButton(1, 15, 1'b0);
    waitCycles(25);

    btn_pause = 1'b0;
    waitCycles(7);
    reset_n = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    checkValue("q after mid-debounce reset", int'(qW), 0);
    checkValue("running after mid-debounce reset", int'(runW), 1);
    waitCycles(10);
    checkValue("no early toggle while held", int'(runW), 1);
    waitCycles(10);
    checkValue("one toggle from held button", int'(runW), 0);
    btn_pause = 1'b1;
    waitCycles(15);

    for (int i = 0; i < 150; i++) applyStimulus();
    btn_pause = 1'b1;
    btn_dir   = 1'b1;
    waitCycles(40);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
